// File: rtl/padframe_loopback_bist_pkg.sv
// Shared types and constants for the padframe loopback BIST.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package padframe_pkg;

    // Pads per direction on the sg13g2 frame.
    localparam int PAD_WIDTH = 14;

    // Alternating-bit vectors; A drives the odd bits, B the even bits.
    localparam logic [PAD_WIDTH-1:0] CHECKER_A = 14'h2AAA;
    localparam logic [PAD_WIDTH-1:0] CHECKER_B = 14'h1555;

    // Fibonacci LFSR taps 14,5,3,1 -> bit positions 13,4,2,0.
    localparam logic [PAD_WIDTH-1:0] LFSR_TAPS = 14'h2015;
    localparam logic [PAD_WIDTH-1:0] LFSR_SEED = 14'h0001;

    typedef enum logic [1:0] {
        PAT_WALK1 = 2'd0,
        PAT_WALK0 = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_LFSR  = 2'd3
    } pat_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/padframe_loopback_bist_pad_sync.sv
// Multi-flop synchronizer bringing the asynchronous ui pad inputs into clk.
// Latency: STAGES cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
module pad_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the pad sample through the flop chain; all stages clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/padframe_loopback_bist.sv
// Padframe loopback BIST: drives test vectors on uo pads, checks looped-back ui pads.
// Latency: 2 + SETTLE_CYCLES + SYNC_STAGES cycles per vector; func paths are combinational.
// Backpressure: none; start is ignored while busy, abort always wins.
module padframe_loopback_bist
    import padframe_pkg::*;
#(
    parameter int WIDTH         = PAD_WIDTH,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int LFSR_VECTORS  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       pattern_sel,
    input  logic [WIDTH-1:0] func_out,
    output logic [WIDTH-1:0] func_in,
    output logic [WIDTH-1:0] uo_out,
    input  logic [WIDTH-1:0] ui_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] err_mask,
    output logic [7:0]       err_count
);

    // WAIT counts 0..WAIT_LAST so it spans SETTLE_CYCLES + SYNC_STAGES cycles.
    localparam logic [4:0] WAIT_LAST = 5'(SETTLE_CYCLES + SYNC_STAGES - 1);

    state_e           state_q;
    pat_e             pat_q;
    logic [WIDTH-1:0] vec_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] err_mask_q;
    logic [7:0]       err_count_q;
    logic [7:0]       idx_q;
    logic [4:0]       wait_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [WIDTH-1:0] ui_sync;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] vec_first;
    logic [WIDTH-1:0] vec_d;
    logic [7:0]       idx_d;
    logic             last_vec;
    pat_e             pat_req;

    // Vector i of a pattern; the LFSR value is supplied by the caller.
    function automatic logic [WIDTH-1:0] pattern_vec(input pat_e pat, input logic [7:0] idx,
                                                     input logic [WIDTH-1:0] lfsr);
        logic [WIDTH-1:0] one_hot;
        logic [WIDTH-1:0] result;
        one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
        case (pat)
            PAT_WALK1: result = one_hot;
            PAT_WALK0: result = ~one_hot;
            PAT_CHECK: result = (idx == 8'd0) ? WIDTH'(CHECKER_A) : WIDTH'(CHECKER_B);
            default:   result = lfsr;
        endcase
        return result;
    endfunction

    // Index of the final vector of a pattern.
    function automatic logic [7:0] last_index(input pat_e pat);
        logic [7:0] result;
        case (pat)
            PAT_WALK1, PAT_WALK0: result = 8'(WIDTH - 1);
            PAT_CHECK:            result = 8'd1;
            default:              result = 8'(LFSR_VECTORS - 1);
        endcase
        return result;
    endfunction

    // Raw ui_in only reaches the checker through the synchronizer.
    pad_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (WIDTH)
    ) u_pad_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (ui_in),
        .q_o    (ui_sync)
    );

    // Next-vector, compare and LFSR step logic feeding the FSM.
    always_comb begin
        pat_req   = pat_e'(pattern_sel);
        diff      = ui_sync ^ vec_q;
        mask_d    = err_mask_q | diff;
        lfsr_d    = {lfsr_q[WIDTH-2:0], ^(lfsr_q & WIDTH'(LFSR_TAPS))};
        idx_d     = idx_q + 8'd1;
        vec_first = pattern_vec(pat_req, 8'd0, WIDTH'(LFSR_SEED));
        vec_d     = pattern_vec(pat_q, idx_d, lfsr_d);
        last_vec  = (idx_q == last_index(pat_q));
    end

    // Test sequencer: drive a vector, let it settle and synchronize, check, repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= PAT_WALK1;
            vec_q       <= '0;
            lfsr_q      <= WIDTH'(LFSR_SEED);
            err_mask_q  <= '0;
            err_count_q <= '0;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else if (abort) begin
            // Results are kept for inspection; only the run itself is dropped.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_DRIVE;
                        pat_q       <= pat_req;
                        vec_q       <= vec_first;
                        lfsr_q      <= WIDTH'(LFSR_SEED);
                        err_mask_q  <= '0;
                        err_count_q <= '0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= S_CHECK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 5'd1;
                    end
                end
                S_CHECK: begin
                    err_mask_q <= mask_d;
                    if ((diff != '0) && (err_count_q != 8'hFF)) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                    if (last_vec) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (mask_d == '0);
                    end else begin
                        state_q <= S_DRIVE;
                        idx_q   <= idx_d;
                        lfsr_q  <= lfsr_d;
                        vec_q   <= vec_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    // The core owns the uo pads whenever no test is running.
    assign uo_out    = ((state_q == S_IDLE) || (state_q == S_DONE)) ? func_out : vec_q;
    assign func_in   = ui_in;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;

endmodule

// File: doc/padframe_loopback_bist.md
# padframe_loopback_bist

Built-in self-test controller for the 14-in/14-out sg13g2 padframe. Sits between the core and the pad ring. In functional mode it passes core outputs to the `uo` pads and pad inputs to the core. On request it takes over the `uo` pads and drives a pattern sequence onto them. It then checks the `ui` pads, which are looped back externally on the test board or probe card, and reports per-bit stuck or bridged pad faults.

## Interface
- `WIDTH`, 14, number of pad bits per direction (`ui` and `uo`).
- `SETTLE_CYCLES`, 4, wait cycles after a new vector is driven, to cover pad and board propagation; range 1..15.
- `SYNC_STAGES`, 2, synchronizer depth on `ui_in`; range 2..3.
- `LFSR_VECTORS`, 64, number of vectors in LFSR mode; range 1..255.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; starts a test when the FSM is IDLE.
- `abort`  in  1  level; forces a return to IDLE with no `done`.
- `pattern_sel`  in  2  pattern: 0 walking-ones, 1 walking-zeros, 2 checkerboard, 3 LFSR.
- `func_out`  in  WIDTH  core data destined for the `uo` pads.
- `func_in`  out  WIDTH  `ui` pad data to the core; combinational passthrough of `ui_in`.
- `uo_out`  out  WIDTH  drives the `uo` pad `c2p` pins.
- `ui_in`  in  WIDTH  from the `ui` pad `p2c` pins; asynchronous relative to `clk`.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE; held until the next accepted `start`.
- `pass`  out  1  `done && err_mask == 0`.
- `err_mask`  out  WIDTH  sticky OR of the per-bit mismatches across all checked vectors.
- `err_count`  out  8  number of failing vectors; saturates at 255.

## Operation
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- In IDLE and DONE, `uo_out = func_out` through a combinational mux. In every other state, `uo_out = vec_q` (registered pattern vector).
- Reset values: state IDLE, `vec_q` = 0, `err_mask` = 0, `err_count` = 0, `done` = 0, `busy` = 0, `pass` = 0, vector index = 0, synchronizer flops = 0, LFSR = 0x0001.
- `start` is accepted in IDLE or DONE. On acceptance:
  - clear `err_mask`, `err_count`, `done` and the vector index;
  - load the first vector into `vec_q`;
  - latch `pattern_sel`; later changes to the input are ignored until the next run;
  - go to DRIVE.
- `start` while `busy` is ignored.
- DRIVE lasts 1 cycle, then goes to WAIT. WAIT lasts `SETTLE_CYCLES + SYNC_STAGES` cycles, counted by a 5-bit counter, then goes to CHECK.
- CHECK lasts 1 cycle and computes `diff = ui_sync ^ vec_q`:
  - `err_mask |= diff`;
  - if `diff != 0`, `err_count` += 1, saturating at 255;
  - if the last vector was checked, go to DONE; otherwise advance `vec_q` and the index and go to DRIVE.
- Vector sequences:
  - Walking-ones: `1<<i`, i = 0..WIDTH-1 (14 vectors).
  - Walking-zeros: `~(1<<i)` (14 vectors).
  - Checkerboard: 0x2AAA, then 0x1555 (2 vectors).
  - LFSR: 14-bit Fibonacci LFSR, taps 14,5,3,1, seed 0x0001, `LFSR_VECTORS` vectors. The LFSR steps once per vector. The first vector is the seed.
- `abort` has priority over all transitions:
  - next state IDLE; `busy` = 0, `done` = 0;
  - `err_mask` and `err_count` hold their values;
  - `uo_out` returns to `func_out` on the next cycle.
- `rst` mid-test has the same effect as `abort`, and additionally returns every register to its reset value.

## Timing
- Per-vector cost: `2 + SETTLE_CYCLES + SYNC_STAGES` cycles, which is 8 at the defaults.
- Default run lengths, from `start` sampled high to `done` high: walking patterns 112 cycles, checkerboard 16 cycles, LFSR 512 cycles.
- `uo_out` changes in the cycle after entering DRIVE, because `vec_q` is registered.
- `ui_in` reaches the comparator only through the `SYNC_STAGES` flops. No raw `ui_in` feeds any FSM logic.
- `done`, `pass`, `err_mask` and `err_count` are all registered outputs.
- `busy` deasserts in the same cycle that `done` asserts.

## Structure
- Shared package `padframe_pkg`:
  - `WIDTH` default;
  - pattern-select enum;
  - FSM state enum;
  - checkerboard constants;
  - LFSR tap mask.
- One natural sub-module: `pad_sync`, a parameterized `SYNC_STAGES` x `WIDTH` flop synchronizer, reset to 0.
- Pattern generation and the FSM stay in the top module.

## Test plan
- Loopback ideal (`ui_in = uo_out` delayed 1 cycle), `pattern_sel` = 0 → `done` after 112 cycles; `pass` = 1; `err_mask` = 0x0000; `err_count` = 0.
- Bit 5 of `ui_in` stuck at 0, walking-ones → `err_mask` = 0x0020; `err_count` = 1; `pass` = 0.
- Bits 3 and 4 bridged (wired-OR), checkerboard → `err_mask` = 0x0018; `err_count` = 2.
- LFSR with ideal loopback → `uo_out` sequence starts 0x0001 and matches the reference LFSR model for 64 vectors; `pass` = 1 at cycle 512.
- `abort` asserted during vector 7 of walking-zeros → IDLE next cycle; `done` = 0; `uo_out` = `func_out`. A `start` pulse during the run is ignored; a later `start` runs the test again with cleared results.
- `rst` asserted mid-run for 1 cycle → all outputs at their reset values the next cycle; `uo_out` = `func_out`; `func_in` tracks `ui_in` throughout.
